// File: rtl/esn7e_demo_system_nios2_qsys_mult_unit_pkg.sv
// Shared types and helpers for the iterative Nios II multiply unit.
// Build option: MULT_CELL_HIGH_EN enables the high-word ops (MULXSS/MULXSU/MULXUU)
// and the full N*N partial-product sweep; without it only the low word is produced.
package esn7e_mult_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULXSS = 2'd1,
    OP_MULXSU = 2'd2,
    OP_MULXUU = 2'd3
  } mult_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mult_state_e;

`ifdef MULT_CELL_HIGH_EN
  localparam bit HIGH_EN = 1'b1;
`else
  localparam bit HIGH_EN = 1'b0;
`endif

  // Number of CALC cycles: all chunk pairs for high ops, only pairs that
  // land in the low word otherwise.
  function automatic int n_steps(input int data_w, input int part_w, input bit high_en);
    int n;
    n = data_w / part_w;
    return high_en ? n * n : (n * (n + 1)) / 2;
  endfunction

  // Operands must split into at least two whole chunks.
  function automatic bit cfg_ok(input int data_w, input int part_w);
    return (part_w > 0) && ((data_w % part_w) == 0) && ((data_w / part_w) >= 2);
  endfunction

endpackage

// File: rtl/esn7e_demo_system_nios2_qsys_mult_unit_if.sv
// Request/response handshake bundle between the A-stage and the multiply unit.
// Build option: MULT_CELL_HIGH_EN (not referenced here; in_op is always carried).
interface esn7e_demo_system_nios2_qsys_mult_unit_if
  import esn7e_mult_pkg::*;
#(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  mult_op_e          in_op;
  logic [DATA_W-1:0] in_src1;
  logic [DATA_W-1:0] in_src2;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;

  modport master (
    output in_valid, in_op, in_src1, in_src2, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/esn7e_demo_system_nios2_qsys_mult_pp.sv
// One unsigned PART_W x PART_W partial product; sized to map onto a single
// hard multiplier block.
module esn7e_demo_system_nios2_qsys_mult_pp #(
  parameter int PART_W = 16
) (
  input  logic [PART_W-1:0]   a,
  input  logic [PART_W-1:0]   b,
  output logic [2*PART_W-1:0] p
);
  // Zero-extend both operands so the product is taken unsigned at full width.
  assign p = (2*PART_W)'(a) * (2*PART_W)'(b);
endmodule

// File: rtl/esn7e_demo_system_nios2_qsys_mult_unit.sv
// Iterative chunked multiplier: one partial product per cycle into a wide
// accumulator, then low word or sign-corrected high word.
// Build option: MULT_CELL_HIGH_EN (undefined -> low word only, triangular sweep,
// DATA_W-wide accumulator, no high-word correction).
module esn7e_demo_system_nios2_qsys_mult_unit
  import esn7e_mult_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PART_W = 16
) (
  input logic clk,
  input logic reset,
  input logic flush,
  esn7e_demo_system_nios2_qsys_mult_unit_if.slave bus
);

  localparam int N     = DATA_W / PART_W;
  localparam int S     = n_steps(DATA_W, PART_W, HIGH_EN);
  localparam int IDX_W = (N > 2) ? $clog2(N) : 1;
  localparam int CNT_W = (S > 2) ? $clog2(S) : 1;
  localparam int ACC_W = HIGH_EN ? 2 * DATA_W : DATA_W;

  if (!cfg_ok(DATA_W, PART_W)) begin : g_cfg_bad
    $error("mult_unit: DATA_W must be a multiple of PART_W with at least two chunks");
  end

  mult_state_e        state;
  logic [DATA_W-1:0]  src1_q;
  logic [DATA_W-1:0]  src2_q;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   step_cnt;
  logic [IDX_W-1:0]   idx_i;
  logic [IDX_W-1:0]   idx_j;
  logic               out_valid_q;
  logic [DATA_W-1:0]  out_result_q;

  logic [PART_W-1:0]   chunk_a;
  logic [PART_W-1:0]   chunk_b;
  logic [2*PART_W-1:0] pp;
  logic [ACC_W-1:0]    pp_shifted;
  logic [DATA_W-1:0]   result_sel;
  logic                last_step;
  logic                row_end;

`ifdef MULT_CELL_HIGH_EN
  mult_op_e op_q;

  // Two's-complement correction of the unsigned high word for signed operands.
  function automatic logic [DATA_W-1:0] fix_high(input mult_op_e op,
                                                 input logic [DATA_W-1:0] h,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] r;
    r = $signed(h);
    if (((op == OP_MULXSU) || (op == OP_MULXSS)) && a[DATA_W-1])
      r = r - $signed(b);
    if ((op == OP_MULXSS) && b[DATA_W-1])
      r = r - $signed(a);
    return $unsigned(r);
  endfunction
`else
  logic unused_op;
  assign unused_op = ^bus.in_op;
`endif

  assign bus.in_ready   = (state == ST_IDLE) && !reset;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;

  assign chunk_a = src1_q[PART_W*idx_i +: PART_W];
  assign chunk_b = src2_q[PART_W*idx_j +: PART_W];

  esn7e_demo_system_nios2_qsys_mult_pp #(
    .PART_W (PART_W)
  ) u_pp (
    .a (chunk_a),
    .b (chunk_b),
    .p (pp)
  );

  assign pp_shifted = ACC_W'(pp) << (PART_W * (int'(idx_i) + int'(idx_j)));
  assign last_step  = (step_cnt == CNT_W'(S - 1));
  // Inner index wraps at the last chunk, or at the low-word boundary when the
  // upper partial products are not needed.
  assign row_end    = (idx_i == IDX_W'(N - 1)) ||
                      (!HIGH_EN && ((int'(idx_i) + int'(idx_j)) == (N - 1)));

  // Result selection from the finished accumulator.
  always_comb begin
`ifdef MULT_CELL_HIGH_EN
    if (op_q == OP_MUL)
      result_sel = acc[DATA_W-1:0];
    else
      result_sel = fix_high(op_q, acc[2*DATA_W-1:DATA_W], src1_q, src2_q);
`else
    result_sel = acc;
`endif
  end

  // Control FSM with accumulator and registered result; flush aborts anywhere.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      acc          <= '0;
      step_cnt     <= '0;
      idx_i        <= '0;
      idx_j        <= '0;
    end else if (flush) begin
      state       <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        // p0: accept and latch operands
        ST_IDLE: begin
          if (bus.in_valid) begin
            src1_q   <= bus.in_src1;
            src2_q   <= bus.in_src2;
`ifdef MULT_CELL_HIGH_EN
            op_q     <= bus.in_op;
`endif
            acc      <= '0;
            step_cnt <= '0;
            idx_i    <= '0;
            idx_j    <= '0;
            state    <= ST_CALC;
          end
        end
        // p1: one partial product per cycle, j outer, i inner
        ST_CALC: begin
          acc      <= acc + pp_shifted;
          step_cnt <= step_cnt + CNT_W'(1);
          if (row_end) begin
            idx_i <= '0;
            idx_j <= idx_j + IDX_W'(1);
          end else begin
            idx_i <= idx_i + IDX_W'(1);
          end
          if (last_step)
            state <= ST_FIX;
        end
        // p2: register the selected result
        ST_FIX: begin
          out_result_q <= result_sel;
          out_valid_q  <= 1'b1;
          state        <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
